disp_scan_sched: RTL and testbench
==================================

# disp_scan_sched

Scan scheduler and page arbiter for the 8-digit multiplexed seven-segment display. It drives the digit-select pointer and the digit code into the existing chip-select and segment-decoder stages. It inserts ghost-suppression blank ticks between digits. It shares the display between the always-present base page (frequency/cycle readout) and a transient overlay page requested by another block, switching pages only on frame boundaries so no frame ever shows digits from both pages.

## Interface
Parameters:
- N_DIG, 8 — digits per frame; pointer width is $clog2(N_DIG).
- BLANK_TICKS, 1 — blank ticks inserted after each shown digit; 0 disables the gap.
- HOLD_MS, 1500 — minimum overlay hold time, in clk_1kHz ticks.

Ports:
- clk_1kHz  in  1  scan clock; one tick = 1 ms.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_base_digits  in  5*N_DIG  base page; digit i = [5*i+:5]; bit4 = dot, [3:0] = BCD.
- i_ovl_req  in  1  overlay request, level-sensitive.
- i_ovl_digits  in  5*N_DIG  overlay page, same packing as i_base_digits.
- o_ovl_gnt  out  1  overlay page owns the display.
- o_ovl_done  out  1  one-tick pulse when the hold expires normally.
- o_cs_pointer  out  $clog2(N_DIG)  digit being driven.
- o_blank  out  1  high = no digit lit; downstream must drive segments off.
- o_dig_ctrl  out  5  code for the decoder; 5'b0 whenever o_blank=1.

## Operation
- **Scan FSM** has two states, SHOW and GAP.
  - SHOW lasts 1 tick: o_blank=0 and o_dig_ctrl = framebuf[o_cs_pointer].
  - GAP lasts BLANK_TICKS ticks: o_blank=1 and the pointer holds.
  - After GAP, the FSM returns to SHOW at pointer+1, wrapping from N_DIG-1 to 0.
  - With BLANK_TICKS=0, GAP is skipped.
- **Frame boundary** is the clock edge that enters SHOW at pointer 0. This includes the first edge after reset release.
- **Frame buffer:** all 5*N_DIG bits are loaded at every frame boundary from the page selected on that edge. Input changes mid-frame are invisible until the next boundary.
- **Arbiter FSM** has three states: BASE, OVL, RELEASE. All transitions happen only at frame boundaries.
  - BASE → OVL when i_ovl_req=1. o_ovl_gnt rises on the same edge, the buffer loads i_ovl_digits, and the hold counter clears.
  - OVL → BASE on expiry (hold counter ≥ HOLD_MS) with i_ovl_req=0. o_ovl_done pulses and o_ovl_gnt falls on that edge.
  - OVL → RELEASE on expiry with i_ovl_req=1. o_ovl_done pulses and o_ovl_gnt falls.
  - OVL → BASE on abort (i_ovl_req=0 before expiry). o_ovl_gnt falls and there is no done pulse.
  - Expiry and request drop seen at the same boundary count as expiry: done pulse, then BASE.
  - RELEASE → BASE once i_ovl_req=0. This stops a held request from retriggering.
- **Hold counter:** 11 bits, increments every tick while in OVL and saturates at HOLD_MS.
- **Reset,** including reset mid-overlay, forces BASE with all outputs at their reset values.
- **Outputs:** all are registered.
- **Reset values:** o_cs_pointer=0, o_blank=1, o_dig_ctrl=0, o_ovl_gnt=0, o_ovl_done=0; frame buffer = 0.

## Timing
- Frame length = N_DIG*(1+BLANK_TICKS) ticks; the default is 16 ms (62.5 Hz refresh).
- Page-switch latency from a request or release is at most one frame length.
- Grant high time = HOLD_MS rounded up to a whole number of frames; the default is 1504 ticks.
- o_ovl_done is exactly one tick wide and coincides with the falling edge of o_ovl_gnt.
- Data latency: input digits appear on o_dig_ctrl at most 2 frames after they change.

## Configuration
- Macro: SCAN_OVL_BLINK_EN.
- Defined: while in OVL, a 250-tick phase counter (starting in the ON phase at grant) gates the display. In the OFF phase, o_blank=1 and o_dig_ctrl=0 for every slot; the pointer keeps scanning.
- Undefined: the overlay is shown steadily and no phase counter is synthesised.

## Structure
- Package scan_pkg contains:
  - digit_t (5-bit packed type)
  - arb_e enum {BASE, OVL, RELEASE}
  - scan_e enum {SHOW, GAP}
  - BLANK_CODE = 5'b0
  - BLINK_HALF = 250
- One sub-module, ovl_arbiter, holds the arbiter FSM, hold counter and blink counter. It takes a frame-boundary strobe from the scan logic and returns the page select.

## Test plan
- **Reset release, base = 8 digits 1..8, BLANK_TICKS=1:** o_cs_pointer steps 0..7 every 2 ticks. o_blank alternates 0/1. o_dig_ctrl shows 1..8 on SHOW ticks and 0 on GAP ticks.
- **Base digit 3 changed mid-frame:** the old value persists until the next pointer-0 edge, then the new value appears.
- **i_ovl_req pulsed high at tick 5 and held:** o_ovl_gnt rises at tick 16 and falls at tick 1520. o_ovl_done is high for exactly tick 1520. State goes to RELEASE, with no regrant until req drops and is raised again.
- **i_ovl_req dropped 300 ticks after grant:** o_ovl_gnt falls at the next frame boundary, o_ovl_done stays 0, and the base digits return.
- **i_rst_n asserted mid-overlay:** o_ovl_gnt=0, o_blank=1 and o_cs_pointer=0 immediately. After release, the base page is shown.
- **With SCAN_OVL_BLINK_EN:** during grant, o_blank is forced high for ticks 250–499, 750–999, and so on after grant, while the pointer keeps scanning.

Source files
------------

// File: rtl/scan_pkg.sv
// scan_pkg: shared types and constants for the display scan scheduler.
package scan_pkg;
    typedef logic [4:0] digit_t;
    typedef enum logic [1:0] {BASE, OVL, RELEASE} arb_e;
    typedef enum logic {SHOW, GAP} scan_e;
    localparam digit_t BLANK_CODE = 5'b0;
    localparam int BLINK_HALF = 250;
endpackage

// File: rtl/ovl_arbiter.sv
// ovl_arbiter: base/overlay page arbiter with hold counter; switches only on frame strobes.
// SCAN_OVL_BLINK_EN adds a 250-tick on/off phase counter that blanks the overlay.
module ovl_arbiter
    import scan_pkg::*;
#(
    parameter int HOLD_MS = 1500
) (
    input  logic clk_1kHz,
    input  logic i_rst_n,
    input  logic i_frame,
    input  logic i_ovl_req,
    output logic o_sel,
    output logic o_gnt,
    output logic o_done,
    output logic o_blink_off
);
    arb_e        arb_q, arb_d;
    logic [10:0] hold_q, hold_d;
    logic        gnt_q, done_q, done_d;

    always_comb begin
        arb_d  = arb_q;
        done_d = 1'b0;
        hold_d = (arb_q == OVL && hold_q < 11'(HOLD_MS)) ? hold_q + 11'd1 : hold_q;
        if (i_frame) begin
            if (arb_q == BASE && i_ovl_req) begin
                arb_d  = OVL;
                hold_d = '0;
            end else if (arb_q == OVL && hold_q >= 11'(HOLD_MS)) begin
                // expiry wins over a simultaneous request drop
                done_d = 1'b1;
                arb_d  = i_ovl_req ? RELEASE : BASE;
            end else if (arb_q != BASE && !i_ovl_req) begin
                arb_d = BASE;
            end
        end
    end

    assign o_sel  = (arb_d == OVL);
    assign o_gnt  = gnt_q;
    assign o_done = done_q;

    always_ff @(posedge clk_1kHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            arb_q  <= BASE;
            hold_q <= '0;
            gnt_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            arb_q  <= arb_d;
            hold_q <= hold_d;
            gnt_q  <= o_sel;
            done_q <= done_d;
        end
    end

`ifdef SCAN_OVL_BLINK_EN
    logic [7:0] bcnt_q, bcnt_d;
    logic       off_q, off_d;
    logic       wrap;

    assign wrap = (bcnt_q == 8'(BLINK_HALF - 1));

    always_comb begin
        bcnt_d = bcnt_q;
        off_d  = off_q;
        if (arb_d == OVL && arb_q != OVL) begin
            bcnt_d = '0;
            off_d  = 1'b0;
        end else if (arb_q == OVL) begin
            bcnt_d = wrap ? '0 : bcnt_q + 8'd1;
            off_d  = wrap ? ~off_q : off_q;
        end
    end

    always_ff @(posedge clk_1kHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bcnt_q <= '0;
            off_q  <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            off_q  <= off_d;
        end
    end

    assign o_blink_off = (arb_d == OVL) && off_d;
`else
    assign o_blink_off = 1'b0;
`endif
endmodule

// File: rtl/disp_scan_sched.sv
// disp_scan_sched: 7-seg digit scan with blank gaps and frame-aligned base/overlay paging.
// Optional overlay blinking via SCAN_OVL_BLINK_EN.
module disp_scan_sched
    import scan_pkg::*;
#(
    parameter int N_DIG       = 8,
    parameter int BLANK_TICKS = 1,
    parameter int HOLD_MS     = 1500
) (
    input  logic                       clk_1kHz,
    input  logic                       i_rst_n,
    input  logic [5*N_DIG-1:0]         i_base_digits,
    input  logic                       i_ovl_req,
    input  logic [5*N_DIG-1:0]         i_ovl_digits,
    output logic                       o_ovl_gnt,
    output logic                       o_ovl_done,
    output logic [$clog2(N_DIG)-1:0]   o_cs_pointer,
    output logic                       o_blank,
    output logic [4:0]                 o_dig_ctrl
);
    localparam int PW = $clog2(N_DIG);
    localparam int GW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS + 1) : 1;

    scan_e              state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d, ptr_nxt;
    logic [GW-1:0]      gcnt_q, gcnt_d;
    logic               start_q;
    logic               frame, sel, blink_off;
    logic [5*N_DIG-1:0] fbuf_q, fbuf_d;
    logic               blank_q, blank_d;
    digit_t             dig_q, dig_d;

    assign ptr_nxt = (ptr_q == PW'(N_DIG - 1)) ? '0 : ptr_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gcnt_d  = gcnt_q;
        // first edge after reset always opens a frame at digit 0
        if (start_q) begin
            state_d = SHOW;
            ptr_d   = '0;
        end else if (state_q == SHOW) begin
            if (BLANK_TICKS == 0) begin
                ptr_d = ptr_nxt;
            end else begin
                state_d = GAP;
                gcnt_d  = GW'(1);
            end
        end else if (gcnt_q == GW'(BLANK_TICKS)) begin
            state_d = SHOW;
            ptr_d   = ptr_nxt;
        end else begin
            gcnt_d = gcnt_q + 1'b1;
        end
        frame   = (state_d == SHOW) && (ptr_d == '0) &&
                  (start_q || state_q == GAP || BLANK_TICKS == 0);
        fbuf_d  = frame ? (sel ? i_ovl_digits : i_base_digits) : fbuf_q;
        blank_d = (state_d == GAP) || blink_off;
        dig_d   = blank_d ? BLANK_CODE : fbuf_d[5*ptr_d +: 5];
    end

    always_ff @(posedge clk_1kHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= GAP;
            ptr_q   <= '0;
            gcnt_q  <= '0;
            start_q <= 1'b1;
            fbuf_q  <= '0;
            blank_q <= 1'b1;
            dig_q   <= BLANK_CODE;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gcnt_q  <= gcnt_d;
            start_q <= 1'b0;
            fbuf_q  <= fbuf_d;
            blank_q <= blank_d;
            dig_q   <= dig_d;
        end
    end

    ovl_arbiter #(.HOLD_MS(HOLD_MS)) u_arb (
        .clk_1kHz    (clk_1kHz),
        .i_rst_n     (i_rst_n),
        .i_frame     (frame),
        .i_ovl_req   (i_ovl_req),
        .o_sel       (sel),
        .o_gnt       (o_ovl_gnt),
        .o_done      (o_ovl_done),
        .o_blink_off (blink_off)
    );

    assign o_cs_pointer = ptr_q;
    assign o_blank      = blank_q;
    assign o_dig_ctrl   = dig_q;
endmodule

// File: tb/tb_disp_scan_sched.sv
// tb_disp_scan_sched: randomized scoreboard bench; expected outputs come from a
// frame-arithmetic model of the scan/paging rules (blink included under SCAN_OVL_BLINK_EN).
module tb_disp_scan_sched;
    localparam int N = 8;
    localparam int B = 1;
    localparam int HOLD = 1500;
    localparam int FR = N * (1 + B);

    logic           clk_1kHz = 1'b0;
    logic           i_rst_n = 1'b0;
    logic           i_ovl_req = 1'b0;
    logic [5*N-1:0] i_base_digits, i_ovl_digits;
    logic           o_ovl_gnt, o_ovl_done, o_blank;
    logic [2:0]     o_cs_pointer;
    logic [4:0]     o_dig_ctrl;

    disp_scan_sched #(.N_DIG(N), .BLANK_TICKS(B), .HOLD_MS(HOLD)) dut (
        .clk_1kHz      (clk_1kHz),
        .i_rst_n       (i_rst_n),
        .i_base_digits (i_base_digits),
        .i_ovl_req     (i_ovl_req),
        .i_ovl_digits  (i_ovl_digits),
        .o_ovl_gnt     (o_ovl_gnt),
        .o_ovl_done    (o_ovl_done),
        .o_cs_pointer  (o_cs_pointer),
        .o_blank       (o_blank),
        .o_dig_ctrl    (o_dig_ctrl)
    );

    always #5 clk_1kHz = ~clk_1kHz;

    typedef struct packed {
        logic [2:0] ptr;
        logic       blank;
        logic [4:0] dig;
        logic       gnt;
        logic       done;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0, n_fail = 0, n_push = 0, n_pop = 0;
    int         m_t, m_arb, m_gt;
    logic [4:0] m_fb[N];
    time        t_rel, t_rise, t_fall, t_done;
    logic       got_rise = 1'b0, got_fall = 1'b0, got_done = 1'b0, gnt_prev = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Model: position in frame is tick mod frame length; paging decided at position 0.
    task automatic model_step(logic req);
        int p, ptr;
        logic blank, done;
        logic [5*N-1:0] page;
        p = m_t % FR;
        ptr = p / (1 + B);
        blank = (p % (1 + B)) != 0;
        done = 1'b0;
        if (p == 0) begin
            if (m_arb == 0) begin
                if (req) begin
                    m_arb = 1;
                    m_gt = m_t;
                end
            end else if (m_arb == 1) begin
                if (m_t - m_gt - 1 >= HOLD) begin
                    done = 1'b1;
                    m_arb = req ? 2 : 0;
                end else if (!req) m_arb = 0;
            end else if (!req) m_arb = 0;
            page = (m_arb == 1) ? i_ovl_digits : i_base_digits;
            for (int i = 0; i < N; i++) m_fb[i] = page[5*i +: 5];
        end
`ifdef SCAN_OVL_BLINK_EN
        if (m_arb == 1 && ((m_t - m_gt) / 250) % 2 == 1) blank = 1'b1;
`endif
        sb.push_back('{ptr: 3'(ptr), blank: blank, dig: blank ? 5'd0 : m_fb[ptr],
                       gnt: (m_arb == 1), done: done});
        n_push++;
        m_t++;
    endtask

    task automatic model_reset();
        m_t = 0;
        m_arb = 0;
        m_gt = 0;
        for (int i = 0; i < N; i++) m_fb[i] = 5'd0;
    endtask

    task automatic tick(logic req);
        int k;
        @(negedge clk_1kHz);
        if (!i_rst_n) t_rel = $time;
        i_rst_n = 1'b1;
        i_ovl_req = req;
        k = $urandom_range(0, N - 1);
        if ($urandom_range(0, 3) == 0) i_base_digits[5*k +: 5] = 5'($urandom);
        k = $urandom_range(0, N - 1);
        if ($urandom_range(0, 3) == 0) i_ovl_digits[5*k +: 5] = 5'($urandom);
        model_step(req);
    endtask

    function automatic logic [31:0] tick_of(time t);
        return 32'((t - t_rel - 6) / 10);
    endfunction

    initial begin
        forever begin
            @(posedge clk_1kHz);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                n_pop++;
                chk("ptr", 32'(o_cs_pointer), 32'(e.ptr));
                chk("blank", 32'(o_blank), 32'(e.blank));
                chk("dig", 32'(o_dig_ctrl), 32'(e.dig));
                chk("gnt", 32'(o_ovl_gnt), 32'(e.gnt));
                chk("done", 32'(o_ovl_done), 32'(e.done));
                if (o_ovl_gnt && !gnt_prev && !got_rise) begin got_rise = 1'b1; t_rise = $time; end
                if (!o_ovl_gnt && gnt_prev && !got_fall) begin got_fall = 1'b1; t_fall = $time; end
                if (o_ovl_done && !got_done) begin got_done = 1'b1; t_done = $time; end
                gnt_prev = o_ovl_gnt;
            end
        end
    end

    initial begin
        i_base_digits = {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
        i_ovl_digits = 40'({$urandom, $urandom});
        repeat (3) @(negedge clk_1kHz);
        chk("rst_ptr", 32'(o_cs_pointer), 0);
        chk("rst_blank", 32'(o_blank), 1);
        chk("rst_dig", 32'(o_dig_ctrl), 0);
        chk("rst_gnt", 32'(o_ovl_gnt), 0);
        chk("rst_done", 32'(o_ovl_done), 0);
        model_reset();
        // request from tick 5, held past expiry, then drop and re-raise
        for (int i = 0; i < 5; i++) tick(1'b0);
        for (int i = 0; i < 1600; i++) tick(1'b1);
        chk("gnt_rise_tick", got_rise ? tick_of(t_rise) : 32'hFFFF_FFFF, 16);
        chk("gnt_fall_tick", got_fall ? tick_of(t_fall) : 32'hFFFF_FFFF, 1520);
        chk("done_tick", got_done ? tick_of(t_done) : 32'hFFFF_FFFF, 1520);
        for (int i = 0; i < 60; i++) tick(1'b0);
        // grant then abort around 300 ticks in
        for (int i = 0; i < 320; i++) tick(1'b1);
        for (int i = 0; i < 60; i++) tick(1'b0);
        repeat (4) begin
            int len;
            len = $urandom_range(10, 1800);
            for (int i = 0; i < len; i++) tick(1'b1);
            len = $urandom_range(5, 200);
            for (int i = 0; i < len; i++) tick(1'b0);
        end
        // reset in the middle of an overlay
        for (int i = 0; i < 20; i++) tick(1'b0);
        for (int i = 0; i < 200; i++) tick(1'b1);
        @(negedge clk_1kHz);
        chk("pre_rst_gnt", 32'(o_ovl_gnt), 1);
        i_rst_n = 1'b0;
        i_ovl_req = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(o_ovl_gnt), 0);
        chk("mid_rst_blank", 32'(o_blank), 1);
        chk("mid_rst_ptr", 32'(o_cs_pointer), 0);
        chk("mid_rst_dig", 32'(o_dig_ctrl), 0);
        chk("mid_rst_done", 32'(o_ovl_done), 0);
        repeat (2) @(negedge clk_1kHz);
        model_reset();
        for (int i = 0; i < 60; i++) tick(1'b0);
        repeat (3) @(posedge clk_1kHz);
        #2;
        chk("sb_drained", 32'(sb.size()), 0);
        chk("sb_pops", 32'(n_pop), 32'(n_push));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
